// File: rtl/pong_pkg.sv
// Shared Pong playfield constants, collision codes and ball controller state encoding.
package pong_pkg;

  localparam logic [2:0] COL_NONE   = 3'd0;
  localparam logic [2:0] COL_PADDLE = 3'd1;
  localparam logic [2:0] COL_FLOOR  = 3'd2;
  localparam logic [2:0] COL_CEIL   = 3'd3;
  localparam logic [2:0] COL_NET    = 3'd4;
  localparam logic [2:0] COL_WALL   = 3'd5;

  localparam int PF_NET_X    = 600;
  localparam int PF_TOP_Y    = 73;
  localparam int PF_BOTTOM_Y = 472;
  localparam int BALL_SIZE   = 8;
  localparam int PADDLE_X    = 592;

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_MISS  = 2'd2
  } state_e;

endpackage

// File: rtl/ball_motion_ctrl_if.sv
// Control inputs and ball position/event outputs shared by the ball controller and its clients.
interface ball_motion_ctrl_if;
  logic       GameEnable;
  logic       FrameTick;
  logic [2:0] ColIn;
  logic [9:0] ballPosX;
  logic [9:0] ballPosY;
  logic       ballPosReset;
  logic       ballDirX;
  logic       ballDirY;
  logic       HitPulse;
  logic       MissPulse;

  modport master (
    output GameEnable, FrameTick, ColIn,
    input  ballPosX, ballPosY, ballPosReset, ballDirX, ballDirY, HitPulse, MissPulse
  );

  modport slave (
    input  GameEnable, FrameTick, ColIn,
    output ballPosX, ballPosY, ballPosReset, ballDirX, ballDirY, HitPulse, MissPulse
  );
endinterface

// File: rtl/ball_axis_step.sv
// One-axis ball step: move by step in the given direction, clamped to [min, max].
module ball_axis_step (
  input  logic [9:0] pos_i,
  input  logic       dir_i,
  input  logic [9:0] step_i,
  input  logic [9:0] min_i,
  input  logic [9:0] max_i,
  output logic [9:0] pos_o
);

  logic [10:0] inc;
  logic [10:0] floor_sum;
  logic [9:0]  dec;

  // 11-bit sums so neither direction can wrap before the clamp compare
  assign inc       = {1'b0, pos_i} + {1'b0, step_i};
  assign floor_sum = {1'b0, min_i} + {1'b0, step_i};
  assign dec       = pos_i - step_i;

  always_comb begin
    pos_o = pos_i;
    if (dir_i) begin
      pos_o = (inc > {1'b0, max_i}) ? max_i : inc[9:0];
    end else begin
      pos_o = ({1'b0, pos_i} < floor_sum) ? min_i : dec;
    end
  end

endmodule

// File: rtl/ball_motion_ctrl.sv
// Pong ball position/direction controller: serve delay, per-frame stepping, bounce and miss handling.
module ball_motion_ctrl
  import pong_pkg::*;
#(
  parameter int START_X      = 320,
  parameter int START_Y      = 268,
  parameter int STEP_X       = 2,
  parameter int STEP_Y       = 2,
  parameter int NET_X        = PF_NET_X,
  parameter int TOP_Y        = PF_TOP_Y,
  parameter int BOTTOM_Y     = PF_BOTTOM_Y,
  parameter int SERVE_FRAMES = 60
) (
  input  logic               Clk,
  input  logic               Reset,
  ball_motion_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(SERVE_FRAMES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]       x_q, x_d, y_q, y_d;
  logic             dirx_q, dirx_d, diry_q, diry_d;
  logic             serve_diry_q, serve_diry_d;
  logic             pos_reset_q, pos_reset_d;
  logic             hit_q, hit_d, miss_q, miss_d;

  logic             advance;
  logic             dirx_upd, diry_upd;
  logic [9:0]       x_step, y_step;

  assign advance = bus.GameEnable & bus.FrameTick;

  // Directions are set, never toggled, so a repeated collision code is harmless
  always_comb begin
    dirx_upd = dirx_q;
    diry_upd = diry_q;
    case (bus.ColIn)
      COL_PADDLE: dirx_upd = 1'b0;
      COL_WALL:   dirx_upd = 1'b1;
      COL_CEIL:   diry_upd = 1'b1;
      COL_FLOOR:  diry_upd = 1'b0;
      default:    ;
    endcase
  end

  ball_axis_step u_step_x (
    .pos_i  (x_q),
    .dir_i  (dirx_upd),
    .step_i (10'(STEP_X)),
    .min_i  (10'd0),
    .max_i  (10'(NET_X)),
    .pos_o  (x_step)
  );

  ball_axis_step u_step_y (
    .pos_i  (y_q),
    .dir_i  (diry_upd),
    .step_i (10'(STEP_Y)),
    .min_i  (10'(TOP_Y)),
    .max_i  (10'(BOTTOM_Y - BALL_SIZE)),
    .pos_o  (y_step)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= ST_SERVE;
      cnt_q        <= '0;
      x_q          <= 10'(START_X);
      y_q          <= 10'(START_Y);
      dirx_q       <= 1'b1;
      diry_q       <= 1'b1;
      serve_diry_q <= 1'b1;
      pos_reset_q  <= 1'b1;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      dirx_q       <= dirx_d;
      diry_q       <= diry_d;
      serve_diry_q <= serve_diry_d;
      pos_reset_q  <= pos_reset_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    x_d          = x_q;
    y_d          = y_q;
    dirx_d       = dirx_q;
    diry_d       = diry_q;
    serve_diry_d = serve_diry_q;
    case (state_q)
      ST_SERVE: begin
        if (advance) begin
          if (cnt_q == CNT_W'(SERVE_FRAMES - 1)) begin
            state_d = ST_PLAY;
            cnt_d   = '0;
            dirx_d  = 1'b1;
            diry_d  = serve_diry_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_PLAY: begin
        if (advance) begin
          if (bus.ColIn == COL_NET) begin
            state_d = ST_MISS;
          end else begin
            dirx_d = dirx_upd;
            diry_d = diry_upd;
            x_d    = x_step;
            y_d    = y_step;
          end
        end
      end
      ST_MISS: begin
        // Runs on the first enabled Clk, independent of FrameTick
        if (bus.GameEnable) begin
          state_d      = ST_SERVE;
          cnt_d        = '0;
          x_d          = 10'(START_X);
          y_d          = 10'(START_Y);
          serve_diry_d = ~serve_diry_q;
        end
      end
      default: state_d = ST_SERVE;
    endcase
  end

  always_comb begin
    pos_reset_d = (state_d != ST_PLAY);
    hit_d       = advance && (state_q == ST_PLAY) && (bus.ColIn == COL_PADDLE) && dirx_q;
    miss_d      = bus.GameEnable && (state_q == ST_MISS);
  end

  assign bus.ballPosX     = x_q;
  assign bus.ballPosY     = y_q;
  assign bus.ballPosReset = pos_reset_q;
  assign bus.ballDirX     = dirx_q;
  assign bus.ballDirY     = diry_q;
  assign bus.HitPulse     = hit_q;
  assign bus.MissPulse    = miss_q;

endmodule
